// File: rtl/bg_pixel_encode.sv
// Streaming palette encoder: maps an RGB444 pixel to the index of the nearest
// (L1 distance) entry of a run-time loaded palette, one entry per cycle.
module bg_pixel_encode #(
  parameter int unsigned N_ENTRIES = 29,
  parameter int unsigned IDX_W     = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pal_we,
  input  logic [IDX_W-1:0] pal_addr,
  input  logic [11:0]      pal_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [11:0]      in_pixel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_index,
  output logic             out_exact,
  output logic [5:0]       out_dist
);

  localparam int unsigned PIX_W  = 12;
  localparam int unsigned CH_W   = 4;
  localparam int unsigned DIST_W = 6;

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t              state;
  logic [PIX_W-1:0]    palette [N_ENTRIES];
  logic [PIX_W-1:0]    pixel;
  logic [IDX_W-1:0]    cnt;
  logic [IDX_W-1:0]    best_idx;
  logic [DIST_W-1:0]   best_dist;

  logic [PIX_W-1:0]    entry_c;
  logic [DIST_W-1:0]   dist_c;
  logic                better_c;
  logic [IDX_W-1:0]    cand_idx_c;
  logic [DIST_W-1:0]   cand_dist_c;
  logic                last_c;
  logic                wr_ok_c;

  function automatic logic [CH_W-1:0] abs_diff(input logic [CH_W-1:0] a,
                                               input logic [CH_W-1:0] b);
    return (a > b) ? CH_W'(a - b) : CH_W'(b - a);
  endfunction

  // Distance to the entry under test and the running best including it
  always_comb begin
    entry_c     = palette[cnt];
    dist_c      = DIST_W'(abs_diff(pixel[11:8], entry_c[11:8]))
                + DIST_W'(abs_diff(pixel[7:4],  entry_c[7:4]))
                + DIST_W'(abs_diff(pixel[3:0],  entry_c[3:0]));
    better_c    = dist_c < best_dist;
    cand_idx_c  = better_c ? cnt : best_idx;
    cand_dist_c = better_c ? dist_c : best_dist;
    last_c      = (dist_c == '0) || (cnt == IDX_W'(N_ENTRIES - 1));
    wr_ok_c     = pal_we && (state == IDLE)
                && ({1'b0, pal_addr} < (IDX_W + 1)'(N_ENTRIES));
  end

  // Palette registers; writable only while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N_ENTRIES); i++) palette[i] <= '0;
    end else if (wr_ok_c) begin
      palette[pal_addr] <= pal_data;
    end
  end

  // Search FSM with registered handshake and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_index <= '0;
      out_dist  <= '0;
      out_exact <= 1'b0;
      pixel     <= '0;
      cnt       <= '0;
      best_idx  <= '0;
      best_dist <= '1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            pixel     <= in_pixel;
            cnt       <= '0;
            best_idx  <= '0;
            best_dist <= DIST_W'(63);
            in_ready  <= 1'b0;
            state     <= SEARCH;
          end
        end
        SEARCH: begin
          best_idx  <= cand_idx_c;
          best_dist <= cand_dist_c;
          if (last_c) begin
            out_index <= cand_idx_c;
            out_dist  <= cand_dist_c;
            out_exact <= (cand_dist_c == '0);
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + IDX_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/bg_pixel_encode.md
# bg_pixel_encode

Streaming palette encoder: converts a 12-bit RGB444 pixel into the 5-bit palette index of the matching or nearest palette colour. It is the inverse of the background/menu palette decoders. It sits in the asset-capture path, so pixels from a framebuffer readback or sprite import can be compressed into the 5-bit indexed format that the renderer's decoders expand. The palette is register-loaded at run time, and the search runs sequentially, one entry per cycle.

## Interface
Parameters:
- N_ENTRIES, 29: number of valid palette entries (1..32).
- IDX_W, 5: index width.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pal_we  in  1  palette write strobe.
- pal_addr  in  IDX_W  palette entry to write.
- pal_data  in  12  RGB444 colour to write (R=[11:8], G=[7:4], B=[3:0]).
- in_valid  in  1  input pixel valid.
- in_ready  out  1  encoder can accept a pixel.
- in_pixel  in  12  RGB444 pixel to encode.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_index  out  IDX_W  best-match palette index.
- out_exact  out  1  1 when out_dist == 0.
- out_dist  out  6  L1 distance |dR|+|dG|+|dB| (max 45).

## Operation
- Palette: N_ENTRIES x 12-bit registers, all cleared to 12'h000 on reset.
  - A write with pal_we=1 occurs only when the FSM is in IDLE.
  - Writes in SEARCH or DONE are silently dropped.
  - Writes with pal_addr >= N_ENTRIES are dropped.
- FSM states: IDLE, SEARCH, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch in_pixel, clear the entry counter to 0, set best_dist=6'd63 and best_idx=0, then go to SEARCH.
- SEARCH (in_ready=0):
  - Each cycle, compute the L1 distance d between the latched pixel and palette[cnt].
  - Per-channel absolute difference is 4 bits unsigned; the sum is 6 bits with no overflow.
  - If d < best_dist (strict), update best_dist and best_idx. Ties therefore keep the lowest index.
  - Go to DONE when d == 0 (early exit) or cnt == N_ENTRIES-1. Otherwise cnt increments.
  - The result registers load on the same edge as the transition.
- DONE:
  - out_valid=1; out_index, out_dist and out_exact are stable.
  - On out_ready, go to IDLE.
  - Outputs hold while out_ready=0; nothing changes and no new pixel is accepted.
- Simultaneous pal_we and input acceptance in IDLE: the write completes on the same edge, and the search sees the new value.
- Reset asserted at any time, including mid-search:
  - state=IDLE, out_valid=0, out_index=0, out_dist=0, out_exact=0.
  - The palette is cleared and the in-flight pixel is discarded.
  - in_ready is 1 while in reset (IDLE).

## Timing
- Acceptance edge E0. Entry i is compared in the cycle after edge E0+i.
- out_valid rises after edge E(k+1), where k is the last entry compared. Latency is k+1 cycles:
  - exact hit on entry 0: 1 cycle;
  - full search: N_ENTRIES cycles.
- Result handshake completes on the edge where out_valid&out_ready.
  - in_ready rises in the following cycle (IDLE).
  - The earliest next acceptance is one edge later.
  - Minimum issue interval: k+3 cycles.
- in_ready and out_valid are pure functions of state: registered, with no combinational path from in_valid or out_ready.
- out_* registers change only on entry to DONE or on reset.

## Test plan
The palette for scenarios 1–5 is the background palette, loaded via pal_we in IDLE:
- entry 0 = CEE, 1 = CEF, 2 = CE7, 3 = AC8, 4 = 7A7, 5 = FFA, 6 = FFB, 7 = DEF, 8 = DFF, 9 = DEA;
- entry 10 = BD9, 11 = 9B7, 12 = EFC, 13 = DEB, 14 = EFF, 15 = FFF, 16 = FFE, 17 = FFC, 18 = BE5, 19 = 9C5;
- entry 20 = 8A7, 21 = 795, 22 = 793, 23 = 673, 24 = 562, 25 = 452, 26 = 121, 27 = 231, 28 = 232.

1. Pixel 12'hCEE -> out_index=0, out_dist=0, out_exact=1, out_valid 1 cycle after acceptance.
2. Pixel 12'hFFF -> out_index=15, out_exact=1, latency 16 cycles.
3. Pixel 12'h000 -> full search, out_index=26 (121), out_dist=4, out_exact=0, latency 29 cycles.
4. Pixel 12'hDEE, tie between entry 0 and entry 7 at dist 1 -> out_index=0, out_dist=1.
5. Pixel 12'h000 with out_ready held low for 5 cycles after out_valid -> outputs and out_valid hold, in_ready=0 throughout. Additionally, pal_we to entry 26 with data 12'h000 during SEARCH is dropped, so the result is still index 26, dist 4.
6. Reset pulse mid-search at cycle 10 of pixel 12'h000 -> all outputs return to reset values and the palette reads 000. A following pixel 12'h000 then gives index 0, dist 0, exact 1, latency 1.
